// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon datapath slice.
package ascon_pack;

   typedef enum logic {FILL, FULL} gather_state_t;

   // One Ascon-128 rate block is 64 bits, i.e. two words of the 32-bit bus.
   localparam int RATE_WORDS = 2;

endpackage

// File: rtl/register_w_en.sv
// Plain register with load enable and asynchronous active-low reset to zero.
module register_w_en #(
   parameter int nb_bits_g = 32
) (
   input  logic                 clock_i,
   input  logic                 resetb_i,
   input  logic                 en_i,
   input  logic [nb_bits_g-1:0] data_i,
   output logic [nb_bits_g-1:0] data_o
);

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         data_o <= '0;
      end else if (en_i) begin
         data_o <= data_i;
      end
   end

endmodule

// File: rtl/word_gather_reg.sv
// Gathers NB_WORDS_G bus words into one block (first word in the MSBs) with
// valid/ready on both sides, partial final blocks and a synchronous clear.
module word_gather_reg
   import ascon_pack::*;
#(
   parameter  int WORD_W_G   = 32,
   parameter  int NB_WORDS_G = RATE_WORDS,
   localparam int CNT_W_G    = $clog2(NB_WORDS_G + 1)
) (
   input  logic                           clock_i,
   input  logic                           resetb_i,
   input  logic                           clear_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [WORD_W_G-1:0]            data_i,
   input  logic                           last_i,
   output logic                           block_valid_o,
   input  logic                           block_ready_i,
   output logic [WORD_W_G*NB_WORDS_G-1:0] block_o,
   output logic [CNT_W_G-1:0]             nb_words_o,
   output logic                           last_o
);

   localparam logic [CNT_W_G-1:0] NB_WORDS_C = CNT_W_G'(NB_WORDS_G);
   localparam logic [CNT_W_G-1:0] ONE_C      = CNT_W_G'(1);

   gather_state_t        state, state_n;
   logic [CNT_W_G-1:0]   cnt, cnt_n, cnt_inc, nb_words_n;
   logic                 last_n;
   logic                 accept;
   logic                 xfer;

   // Ready passes straight through in FULL so a draining block can refill at once.
   assign in_ready_o    = (state == FILL) || block_ready_i;
   assign block_valid_o = (state == FULL);
   assign accept        = in_valid_i && in_ready_o;
   assign xfer          = block_valid_o && block_ready_i;
   assign cnt_inc       = cnt + ONE_C;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state      <= FILL;
         cnt        <= '0;
         nb_words_o <= '0;
         last_o     <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         nb_words_o <= nb_words_n;
         last_o     <= last_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      nb_words_n = nb_words_o;
      last_n     = last_o;
      if (clear_i) begin
         state_n    = FILL;
         cnt_n      = '0;
         nb_words_n = '0;
         last_n     = 1'b0;
      end else if (state == FILL) begin
         if (accept) begin
            cnt_n = cnt_inc;
            if ((cnt_inc == NB_WORDS_C) || last_i) begin
               state_n    = FULL;
               nb_words_n = cnt_inc;
               last_n     = last_i;
            end
         end
      end else if (xfer) begin
         // A word accepted during the drain opens the next block in slot 0.
         state_n    = FILL;
         cnt_n      = '0;
         nb_words_n = '0;
         last_n     = 1'b0;
         if (accept) begin
            cnt_n = ONE_C;
            if ((NB_WORDS_G == 1) || last_i) begin
               state_n    = FULL;
               nb_words_n = ONE_C;
               last_n     = last_i;
            end
         end
      end
   end

   for (genvar i = 0; i < NB_WORDS_G; i++) begin : g_slot
      logic wr_word;
      logic wr_zero;

      // Zeroing on drain or clear keeps unwritten slots of the next block at 0.
      assign wr_word = !clear_i && accept &&
                       (((state == FILL) && (cnt == CNT_W_G'(i))) ||
                        ((state == FULL) && (i == 0)));
      assign wr_zero = clear_i || xfer;

      register_w_en #(
         .nb_bits_g (WORD_W_G)
      ) u_slot (
         .clock_i  (clock_i),
         .resetb_i (resetb_i),
         .en_i     (wr_word || wr_zero),
         .data_i   (wr_word ? data_i : '0),
         .data_o   (block_o[WORD_W_G*(NB_WORDS_G-i)-1 -: WORD_W_G])
      );
   end

endmodule

// File: tb/tb_word_gather_reg.sv
// Self-checking bench for word_gather_reg: vector table, hand sequences, and a queue-based random model.
module tb_word_gather_reg;

   localparam int W  = 32;
   localparam int N  = 2;
   localparam int BW = W * N;

   logic          clock_i = 1'b0;
   logic          resetb_i;
   logic          clear_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [W-1:0]  data_i;
   logic          last_i;
   logic          block_valid_o;
   logic          block_ready_i;
   logic [BW-1:0] block_o;
   logic [1:0]    nb_words_o;
   logic          last_o;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic          valid;
      logic          last;
      logic          bready;
      logic          clr;
      logic [W-1:0]  data;
      logic          exp_ready;
      logic          exp_valid;
      logic [BW-1:0] exp_block;
      logic [1:0]    exp_nb;
      logic          exp_last;
   } vec_t;

   vec_t vecs[20];

   word_gather_reg #(
      .WORD_W_G   (W),
      .NB_WORDS_G (N)
   ) dut (
      .clock_i       (clock_i),
      .resetb_i      (resetb_i),
      .clear_i       (clear_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .data_i        (data_i),
      .last_i        (last_i),
      .block_valid_o (block_valid_o),
      .block_ready_i (block_ready_i),
      .block_o       (block_o),
      .nb_words_o    (nb_words_o),
      .last_o        (last_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic l, input logic br, input logic c, input logic [W-1:0] d);
      in_valid_i    = v;
      last_i        = l;
      block_ready_i = br;
      clear_i       = c;
      data_i        = d;
   endtask

   task automatic stepCycle();
      @(posedge clock_i);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      resetb_i = 1'b0;
      repeat (2) @(posedge clock_i);
      #1;
      resetb_i = 1'b1;
      #1;
   endtask

   // Zero-filled block image of a list of words, first word in the MSBs.
   function automatic logic [BW-1:0] packWords(input logic [W-1:0] w[$]);
      logic [BW-1:0] blk;
      blk = '0;
      for (int i = 0; i < N; i++) begin
         blk = blk << W;
         if (i < w.size()) blk = blk | BW'(w[i]);
      end
      return blk;
   endfunction

   initial begin
      logic [W-1:0]  pend_q[$];
      logic [W-1:0]  stream_q[$];
      logic [BW-1:0] got_q[$];
      logic [BW-1:0] pres_block;
      logic [1:0]    pres_nb;
      logic          pres_last;
      logic          pres_valid;
      logic          ready_seen_low;

      vecs[0]  = '{1, 0, 0, 0, 32'h01234567, 1, 0, 64'h01234567_00000000, 2'd0, 0};
      vecs[1]  = '{1, 0, 0, 0, 32'h89ABCDEF, 1, 1, 64'h01234567_89ABCDEF, 2'd2, 0};
      vecs[2]  = '{1, 0, 0, 0, 32'h11111111, 0, 1, 64'h01234567_89ABCDEF, 2'd2, 0};
      vecs[3]  = '{1, 1, 0, 0, 32'h22222222, 0, 1, 64'h01234567_89ABCDEF, 2'd2, 0};
      vecs[4]  = '{0, 0, 1, 0, 32'h00000000, 1, 0, 64'h00000000_00000000, 2'd0, 0};
      vecs[5]  = '{1, 1, 0, 0, 32'hDEADBEEF, 1, 1, 64'hDEADBEEF_00000000, 2'd1, 1};
      vecs[6]  = '{1, 0, 0, 0, 32'h33333333, 0, 1, 64'hDEADBEEF_00000000, 2'd1, 1};
      vecs[7]  = '{1, 0, 0, 0, 32'h33333333, 0, 1, 64'hDEADBEEF_00000000, 2'd1, 1};
      vecs[8]  = '{1, 1, 0, 0, 32'h44444444, 0, 1, 64'hDEADBEEF_00000000, 2'd1, 1};
      vecs[9]  = '{1, 0, 0, 0, 32'h55555555, 0, 1, 64'hDEADBEEF_00000000, 2'd1, 1};
      vecs[10] = '{1, 0, 0, 0, 32'h66666666, 0, 1, 64'hDEADBEEF_00000000, 2'd1, 1};
      vecs[11] = '{1, 0, 1, 0, 32'hAAAA5555, 1, 0, 64'hAAAA5555_00000000, 2'd0, 0};
      vecs[12] = '{1, 0, 0, 0, 32'h12345678, 1, 1, 64'hAAAA5555_12345678, 2'd2, 0};
      vecs[13] = '{1, 1, 1, 0, 32'hCAFEF00D, 1, 1, 64'hCAFEF00D_00000000, 2'd1, 1};
      vecs[14] = '{1, 0, 1, 1, 32'h55555555, 1, 0, 64'h00000000_00000000, 2'd0, 0};
      vecs[15] = '{1, 0, 0, 0, 32'h0BADF00D, 1, 0, 64'h0BADF00D_00000000, 2'd0, 0};
      vecs[16] = '{1, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 64'h00000000_00000000, 2'd0, 0};
      vecs[17] = '{1, 0, 0, 0, 32'hA1A1A1A1, 1, 0, 64'hA1A1A1A1_00000000, 2'd0, 0};
      vecs[18] = '{1, 1, 1, 0, 32'hB2B2B2B2, 1, 1, 64'hA1A1A1A1_B2B2B2B2, 2'd2, 1};
      vecs[19] = '{0, 0, 1, 0, 32'h00000000, 1, 0, 64'h00000000_00000000, 2'd0, 0};

      doReset();
      checkOutput("reset block_valid", BW'(block_valid_o), '0);
      checkOutput("reset block", block_o, '0);
      checkOutput("reset nb_words", BW'(nb_words_o), '0);
      checkOutput("reset last", BW'(last_o), '0);
      checkOutput("reset in_ready", BW'(in_ready_o), BW'(1));

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].bready, vecs[i].clr, vecs[i].data);
         #1;
         checkOutput($sformatf("vec%0d in_ready", i), BW'(in_ready_o), BW'(vecs[i].exp_ready));
         stepCycle();
         checkOutput($sformatf("vec%0d block_valid", i), BW'(block_valid_o), BW'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d block", i), block_o, vecs[i].exp_block);
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("vec%0d nb_words", i), BW'(nb_words_o), BW'(vecs[i].exp_nb));
            checkOutput($sformatf("vec%0d last", i), BW'(last_o), BW'(vecs[i].exp_last));
         end
         if (vecs[i].clr) checkOutput($sformatf("vec%0d clear nb_words", i), BW'(nb_words_o), '0);
      end

      // Streaming: eight back-to-back words with the consumer always ready.
      ready_seen_low = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            stream_q.push_back(32'h1000_0000 + W'(i));
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000 + W'(i));
         end else begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
         end
         #1;
         if (!in_ready_o) ready_seen_low = 1'b1;
         if (block_valid_o) got_q.push_back(block_o);
         stepCycle();
      end
      checkOutput("stream in_ready never low", BW'(ready_seen_low), '0);
      checkOutput("stream block count", BW'(got_q.size()), BW'(4));
      for (int b = 0; b < 4 && b < got_q.size(); b++)
         checkOutput($sformatf("stream block%0d", b), got_q[b], {stream_q[2*b], stream_q[2*b+1]});

      // Reset in the middle of a block takes effect without a clock edge.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h77777777);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #2;
      resetb_i = 1'b0;
      #1;
      checkOutput("async reset block", block_o, '0);
      checkOutput("async reset in_ready", BW'(in_ready_o), BW'(1));
      doReset();

      // Random traffic against a queue-based model of gathered and presented blocks.
      pend_q.delete();
      pres_valid = 1'b0;
      pres_block = '0;
      pres_nb    = '0;
      pres_last  = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic v, l, br, c, rdy;
         logic [W-1:0] d;
         v  = ($urandom_range(3) != 0);
         l  = ($urandom_range(3) == 0);
         br = $urandom_range(1) == 1;
         c  = ($urandom_range(15) == 0);
         d  = $urandom;
         applyStimulus(v, l, br, c, d);
         #1;
         rdy = !pres_valid || br;
         checkOutput($sformatf("rand%0d in_ready", cyc), BW'(in_ready_o), BW'(rdy));
         if (c) begin
            pend_q.delete();
            pres_valid = 1'b0;
         end else begin
            if (pres_valid && br) pres_valid = 1'b0;
            if (v && rdy) begin
               pend_q.push_back(d);
               if (pend_q.size() == N || l) begin
                  pres_valid = 1'b1;
                  pres_block = packWords(pend_q);
                  pres_nb    = 2'(pend_q.size());
                  pres_last  = l;
                  pend_q.delete();
               end
            end
         end
         stepCycle();
         checkOutput($sformatf("rand%0d block_valid", cyc), BW'(block_valid_o), BW'(pres_valid));
         checkOutput($sformatf("rand%0d block", cyc), block_o, pres_valid ? pres_block : packWords(pend_q));
         if (pres_valid) begin
            checkOutput($sformatf("rand%0d nb_words", cyc), BW'(nb_words_o), BW'(pres_nb));
            checkOutput($sformatf("rand%0d last", cyc), BW'(last_o), BW'(pres_last));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
